// File: rtl/display_scan_3_digit_if.sv
// Load handshake bundle for display_scan_3_digit.
// The upstream source (master) presents a 12-bit hex value, a per-digit DP mask
// and a leading-zero-blank flag under load_valid. The scanner (slave) returns
// load_ready while its pending register is empty.
//   value_in     [11:0]  three hex nibbles, [3:0] is digit 0
//   dp_mask_in   [2:0]   DP request, bit i belongs to digit i
//   blank_lz_in          enable leading-zero blanking for this value
//   load_valid           the three fields above are valid
//   load_ready           pending register empty, a load can be accepted
interface display_scan_3_digit_if;
   logic [11:0] value_in;
   logic [2:0]  dp_mask_in;
   logic        blank_lz_in;
   logic        load_valid;
   logic        load_ready;

   modport master (
      output value_in, dp_mask_in, blank_lz_in, load_valid,
      input  load_ready
   );

   modport slave (
      input  value_in, dp_mask_in, blank_lz_in, load_valid,
      output load_ready
   );
endinterface

// File: rtl/display_scan_3_digit.sv
// Time-multiplexing scanner feeding a 3-digit seven-segment decoder.
// Holds an active value/mask/blank set and a one-deep pending set. New loads are
// taken into pending and copied to active only at a frame boundary, so a frame
// never mixes digits of two values.
//   clock         system clock, rising edge
//   reset_n       asynchronous active-low reset
//   ld            load handshake (slave side), see display_scan_3_digit_if
//   display_out   digit nibble, to decoder display_in
//   en_out        digit index 0..2, 3 = all digits off, to decoder en_in
//   dp_out        decimal point of current digit, to decoder dp_in
//   frame_tick    one-cycle pulse on the first displayed digit-0 cycle of a frame
//
// Scan FSM (one state per digit slot, advanced when the slot counter wraps)
//   state  | meaning
//   S_DIG0 | digit 0 slot
//   S_DIG1 | digit 1 slot
//   S_DIG2 | digit 2 slot; its last cycle is the frame boundary
module display_scan_3_digit #(
   parameter int PRESCALE = 50000
) (
   input  logic                    clock,
   input  logic                    reset_n,
   display_scan_3_digit_if.slave   ld,
   output logic [3:0]              display_out,
   output logic [1:0]              en_out,
   output logic                    dp_out,
   output logic                    frame_tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] SLOT_LAST = CW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      S_DIG0 = 2'd0,
      S_DIG1 = 2'd1,
      S_DIG2 = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] slot_cnt_q, slot_cnt_d;
   logic [11:0]   act_val_q, act_val_d;
   logic [2:0]    act_mask_q, act_mask_d;
   logic          act_blank_q, act_blank_d;
   logic [11:0]   pend_val_q, pend_val_d;
   logic [2:0]    pend_mask_q, pend_mask_d;
   logic          pend_blank_q, pend_blank_d;
   logic          pend_full_q, pend_full_d;
   logic          frame_start_q;
   logic [3:0]    display_d;
   logic [1:0]    en_d;
   logic          dp_d;

   logic slot_end, boundary, accept;

   assign slot_end      = (slot_cnt_q == SLOT_LAST);
   assign boundary      = slot_end && (state_q == S_DIG2);
   assign ld.load_ready = !pend_full_q;
   assign accept        = ld.load_valid && !pend_full_q;

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= S_DIG0;
      else          state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      if (slot_end) begin
         case (state_q)
            S_DIG0:  state_d = S_DIG1;
            S_DIG1:  state_d = S_DIG2;
            default: state_d = S_DIG0;
         endcase
      end
   end

   // slot timer and active/pending sets
   always_comb begin
      slot_cnt_d   = slot_end ? '0 : slot_cnt_q + 1'b1;
      act_val_d    = act_val_q;
      act_mask_d   = act_mask_q;
      act_blank_d  = act_blank_q;
      pend_val_d   = pend_val_q;
      pend_mask_d  = pend_mask_q;
      pend_blank_d = pend_blank_q;
      pend_full_d  = pend_full_q;
      if (boundary && pend_full_q) begin
         act_val_d   = pend_val_q;
         act_mask_d  = pend_mask_q;
         act_blank_d = pend_blank_q;
         pend_full_d = 1'b0;
      end
      // accept only happens with pending empty, so it never races the copy above;
      // a load landing on the boundary edge waits for the next frame
      if (accept) begin
         pend_val_d   = ld.value_in;
         pend_mask_d  = ld.dp_mask_in;
         pend_blank_d = ld.blank_lz_in;
         pend_full_d  = 1'b1;
      end
   end

   // output logic, from the current slot and active set (registered below)
   always_comb begin
      logic [3:0] nib;
      logic       dp_sel;
      logic       blank;
      logic [1:0] idx;
      nib    = act_val_q[3:0];
      dp_sel = act_mask_q[0];
      blank  = 1'b0;
      idx    = 2'd0;
      case (state_q)
         S_DIG1: begin
            nib    = act_val_q[7:4];
            dp_sel = act_mask_q[1];
            blank  = act_blank_q && (act_val_q[11:4] == 8'h00) &&
                     !act_mask_q[1] && !act_mask_q[2];
            idx    = 2'd1;
         end
         S_DIG2: begin
            nib    = act_val_q[11:8];
            dp_sel = act_mask_q[2];
            blank  = act_blank_q && (act_val_q[11:8] == 4'h0) && !act_mask_q[2];
            idx    = 2'd2;
         end
         default: ;
      endcase
      display_d = blank ? 4'h0 : nib;
      dp_d      = blank ? 1'b0 : dp_sel;
      en_d      = blank ? 2'd3 : idx;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         slot_cnt_q    <= '0;
         act_val_q     <= 12'h000;
         act_mask_q    <= 3'b000;
         act_blank_q   <= 1'b0;
         pend_val_q    <= 12'h000;
         pend_mask_q   <= 3'b000;
         pend_blank_q  <= 1'b0;
         pend_full_q   <= 1'b0;
         frame_start_q <= 1'b0;
         display_out   <= 4'h0;
         en_out        <= 2'd3;
         dp_out        <= 1'b0;
         frame_tick    <= 1'b0;
      end else begin
         slot_cnt_q    <= slot_cnt_d;
         act_val_q     <= act_val_d;
         act_mask_q    <= act_mask_d;
         act_blank_q   <= act_blank_d;
         pend_val_q    <= pend_val_d;
         pend_mask_q   <= pend_mask_d;
         pend_blank_q  <= pend_blank_d;
         pend_full_q   <= pend_full_d;
         // frame_tick rides the same one-cycle output lag as the digit outputs,
         // so it coincides with the first displayed digit-0 cycle of the frame
         frame_start_q <= boundary;
         display_out   <= display_d;
         en_out        <= en_d;
         dp_out        <= dp_d;
         frame_tick    <= frame_start_q;
      end
   end

endmodule

// File: tb/tb_display_scan_3_digit.sv
// Self-checking bench for display_scan_3_digit (PRESCALE=4).
// Reference model: absolute edge count since reset gives the scan position;
// outputs after an edge show the position/active set held before that edge.
module tb_display_scan_3_digit;
   localparam int P  = 4;
   localparam int FR = 3 * P;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] display_out;
   logic [1:0] en_out;
   logic       dp_out;
   logic       frame_tick;

   always #5 clock = ~clock;

   display_scan_3_digit_if lif ();

   display_scan_3_digit #(.PRESCALE(P)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .ld          (lif),
      .display_out (display_out),
      .en_out      (en_out),
      .dp_out      (dp_out),
      .frame_tick  (frame_tick)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   int          m_cyc;
   logic [11:0] m_aval, m_pval;
   logic [2:0]  m_amask, m_pmask;
   logic        m_ablank, m_pblank, m_pfull;
   logic        m_acc, m_bnd;

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, m_cyc);
      end
   endtask

   task automatic model_reset();
      m_cyc = 0;
      m_aval = 12'h000; m_amask = 3'b000; m_ablank = 1'b0;
      m_pval = 12'h000; m_pmask = 3'b000; m_pblank = 1'b0;
      m_pfull = 1'b0; m_acc = 1'b0; m_bnd = 1'b0;
   endtask

   task automatic drive(input logic [11:0] v, input logic [2:0] m, input logic b, input logic vld);
      lif.value_in    = v;
      lif.dp_mask_in  = m;
      lif.blank_lz_in = b;
      lif.load_valid  = vld;
   endtask

   task automatic check_reset_outputs();
      check("rst_en",    en_out,         2'd3);
      check("rst_disp",  display_out,    4'h0);
      check("rst_dp",    dp_out,         1'b0);
      check("rst_tick",  frame_tick,     1'b0);
      check("rst_ready", lif.load_ready, 1'b1);
   endtask

   task automatic step();
      int pos, d;
      logic [3:0] nib;
      logic blk, mb;
      logic [1:0] e_en;
      logic [3:0] e_disp;
      logic e_dp, e_tick;
      @(posedge clock);
      pos = m_cyc % FR;
      d   = pos / P;
      nib = 4'((m_aval >> (4 * d)) & 12'hF);
      mb  = m_amask[d];
      if (d == 2)      blk = m_ablank && m_aval[11:8] == 4'h0 && !m_amask[2];
      else if (d == 1) blk = m_ablank && m_aval[11:8] == 4'h0 && m_aval[7:4] == 4'h0
                             && !m_amask[1] && !m_amask[2];
      else             blk = 1'b0;
      e_en   = blk ? 2'd3 : 2'(d);
      e_disp = blk ? 4'h0 : nib;
      e_dp   = blk ? 1'b0 : mb;
      e_tick = (m_cyc > 0) && (pos == 0);
      m_acc  = lif.load_valid && !m_pfull;
      m_cyc++;
      m_bnd  = (m_cyc % FR == 0);
      if (m_bnd && m_pfull) begin
         m_aval = m_pval; m_amask = m_pmask; m_ablank = m_pblank;
         m_pfull = 1'b0;
      end
      if (m_acc) begin
         m_pval = lif.value_in; m_pmask = lif.dp_mask_in; m_pblank = lif.blank_lz_in;
         m_pfull = 1'b1;
      end
      #1;
      check("en",    en_out,         e_en);
      check("disp",  display_out,    e_disp);
      check("dp",    dp_out,         e_dp);
      check("tick",  frame_tick,     e_tick);
      check("ready", lif.load_ready, !m_pfull);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_to_boundary();
      for (int i = 0; i < 2 * FR; i++) begin
         step();
         if (m_bnd) break;
      end
   endtask

   task automatic send(input logic [11:0] v, input logic [2:0] m, input logic b);
      drive(v, m, b, 1'b1);
      for (int i = 0; i < 4 * FR; i++) begin
         step();
         if (m_acc) break;
      end
      drive(v, m, b, 1'b0);
   endtask

   task automatic reset_mid();
      step();
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      drive(12'h000, 3'b000, 1'b0, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   function automatic logic [11:0] rnd_val();
      logic [11:0] v;
      for (int i = 0; i < 3; i++)
         v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      return v;
   endfunction

   initial begin
      logic [11:0] v;
      logic [2:0]  m;
      logic        b, vld;

      model_reset();
      drive(12'h000, 3'b000, 1'b0, 1'b0);
      #12;
      check_reset_outputs();
      @(negedge clock);
      reset_n = 1'b1;

      // post-reset scan of value 0
      run(FR + 2);

      // load and scan
      send(12'hA3F, 3'b000, 1'b0);
      run(3 * FR);

      // frame integrity: second load mid-frame, third load ignored while full
      send(12'h123, 3'b000, 1'b0);
      run_to_boundary();
      run(5);
      send(12'h456, 3'b000, 1'b0);
      drive(12'h789, 3'b111, 1'b0, 1'b1);
      run(2);
      drive(12'h789, 3'b111, 1'b0, 1'b0);
      run(3 * FR);

      // blanking cases
      send(12'h007, 3'b000, 1'b1);
      run(2 * FR);
      send(12'h000, 3'b010, 1'b1);
      run(2 * FR);
      send(12'h050, 3'b000, 1'b1);
      run(2 * FR);

      // back-to-back: valid held high, fresh data after each accept
      drive(rnd_val(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
      for (int i = 0; i < 6 * FR; i++) begin
         step();
         if (m_acc) drive(rnd_val(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
      end
      drive(12'h000, 3'b000, 1'b0, 1'b0);
      run(FR);

      // random traffic; data held stable while valid waits for ready
      vld = 1'b0; v = 12'h000; m = 3'b000; b = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (m_acc || !vld) begin
            vld = ($urandom_range(0, 2) == 0);
            v   = rnd_val();
            m   = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            b   = 1'($urandom_range(0, 1));
         end
         drive(v, m, b, vld);
         step();
      end
      drive(12'h000, 3'b000, 1'b0, 1'b0);

      // reset mid-frame with a pending load outstanding
      send(12'hBCD, 3'b101, 1'b0);
      reset_mid();
      run(FR + 2);

      // reset while displaying a nonzero value
      send(12'hE01, 3'b000, 1'b0);
      run_to_boundary();
      run(P + 1);
      reset_mid();
      run(FR + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/display_scan_3_digit.md
# display_scan_3_digit

Time-multiplexing scanner that drives the 3-digit seven-segment decoder stage. It holds a 12-bit hex value (three nibbles), a per-digit decimal-point mask and a leading-zero-blank flag, and produces one digit nibble, digit select and DP bit per scan slot. Those outputs connect directly to the decoder's `display_in`, `en_in` and `dp_in`. New values are accepted through a valid/ready handshake and applied only at a frame boundary, so a frame never mixes digits from two different values.

## Interface
- `PRESCALE`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `value_in`  in  12  hex value; [3:0] is digit 0, [7:4] is digit 1, [11:8] is digit 2.
- `dp_mask_in`  in  3  DP request per digit; bit i belongs to digit i.
- `blank_lz_in`  in  1  enables leading-zero blanking for this value.
- `load_valid`  in  1  `value_in`, `dp_mask_in` and `blank_lz_in` are valid.
- `load_ready`  out  1  pending register is empty, so a load can be accepted.
- `display_out`  out  4  digit nibble, goes to the decoder's `display_in`.
- `en_out`  out  2  digit index 0..2; value 3 means all digits off. Goes to the decoder's `en_in`.
- `dp_out`  out  1  decimal point for the current digit. Goes to the decoder's `dp_in`.
- `frame_tick`  out  1  one-cycle pulse marking the start of a frame.

## Operation
- State registers:
  - `slot_cnt`, counts 0..PRESCALE-1.
  - `idx`, counts 0..2.
  - Active set: value, mask and blank flag.
  - Pending set plus a `pending_full` flag.
- `load_ready` = !`pending_full`; it is combinational.
- Load accept: on a rising edge with `load_valid` && `load_ready`, the inputs are copied into the pending set and `pending_full` is set to 1.
- Slot advance:
  - `slot_cnt` increments every cycle.
  - When `slot_cnt` == PRESCALE-1, `slot_cnt` goes to 0 and `idx` advances 0→1→2→0.
- Frame boundary is the edge where `slot_cnt` == PRESCALE-1 and `idx` == 2. On that edge:
  - `idx` goes to 0.
  - If `pending_full`, the active set is loaded from the pending set and `pending_full` is cleared.
  - `frame_tick` is set to 1 for exactly the following cycle.
- Load and boundary on the same edge:
  - This cannot happen with `pending_full`=1, because `load_ready` is then 0.
  - With `pending_full`=0, the load goes into pending and is applied at the next boundary, not the current one.
- Blanking, evaluated on the active set:
  - digit 2 is blanked when `blank_lz` && nib2==0 && !mask[2].
  - digit 1 is blanked when `blank_lz` && nib2==0 && nib1==0 && !mask[1] && !mask[2].
  - digit 0 is never blanked.
- Output generation, registered every cycle from the current `idx` and active set:
  - `display_out` = nibble[`idx`].
  - `dp_out` = mask[`idx`].
  - `en_out` = 3 if the current digit is blanked, else `idx`.
  - A blanked slot drives `display_out`=0 and `dp_out`=0.
- `load_valid` without `load_ready` is ignored; the upstream source holds its data until `load_ready` is high.

## Timing
- Reset values, applied asynchronously while `reset_n`=0:
  - `slot_cnt`=0, `idx`=0.
  - Active value=0, mask=0, blank flag=0.
  - `pending_full`=0.
  - `display_out`=0, `en_out`=3, `dp_out`=0, `frame_tick`=0.
  - `load_ready`=1.
- First edge after reset release: outputs show digit 0 of value 0, i.e. `en_out`=0, `display_out`=0.
- Output latency: outputs lag `idx` and the active set by 1 cycle. Digit i is therefore visible for exactly PRESCALE cycles, and a frame lasts 3·PRESCALE cycles.
- Load-to-display latency: the new value's digit 0 appears on the cycle after the first boundary edge that follows the accept edge. This is the same cycle `frame_tick` is high. Maximum latency is 3·PRESCALE+1 cycles.
- `load_ready` falls on the accept edge and rises on the boundary edge that consumes pending.
- Reset asserted mid-frame or mid-load: all state returns to the reset values immediately and pending data is discarded.
- Counter width is $clog2(PRESCALE). No value of `slot_cnt` above PRESCALE-1 is ever reachable.

## Test plan
All scenarios run with PRESCALE=4.
- Reset check: assert `reset_n`=0 mid-slot → outputs go immediately to `en_out`=3, `display_out`=0, `dp_out`=0, `frame_tick`=0, `load_ready`=1. After release, `en_out` follows 0,0,0,0,1,1,1,1,2,2,2,2 with `display_out`=0.
- Load and scan: load 12'hA3F, mask 3'b000, `blank_lz`=0 → after the next boundary, `en_out`/`display_out` sequence 0/F ×4, 1/3 ×4, 2/A ×4, repeating. `frame_tick` pulses once every 12 cycles, aligned with the first digit-0 cycle.
- Frame integrity: load 12'h123, then load 12'h456 in the middle of the frame displaying 123 → that frame completes as 3,2,1 and the next frame shows 6,5,4. While pending is full, `load_ready`=0 and a third `load_valid` is ignored.
- Blanking: 12'h007 with `blank_lz`=1, mask 0 → `en_out` sequence 0,3,3 and `display_out` 7,0,0.
  - 12'h000 with mask 3'b010 → digit 1 is shown with `dp_out`=1, digit 2 is blanked.
  - 12'h050 → digits 0 and 1 are shown, digit 2 is blanked.
- Back-to-back boundary: hold `load_valid`=1 continuously → exactly one accept per frame, each accepted value is displayed for exactly one full frame, and `load_ready` shows a 1-cycle gap after each accept.
